// File: rtl/scan_sequencer.sv
// Purpose: steps a 3-bit index (0..7 or 7..0) for a one-hot decoder, holding each index dwell+1 cycles, single-pass or continuous.
// Latency: a start accepted at edge N shows the first index in cycle N+1; all outputs are registered.
// Backpressure: none; start is ignored while busy, and stop aborts the scan at the next edge.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic               dir_down,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_cont;
    logic               cfg_down;

    logic               at_last;
    logic [2:0]         first_idx;
    logic [2:0]         sel_step;

    // Index bookkeeping derived from the captured direction only.
    assign first_idx = cfg_down ? 3'd7 : 3'd0;
    assign at_last   = cfg_down ? (sel == 3'd0) : (sel == 3'd7);
    assign sel_step  = cfg_down ? (sel - 3'd1) : (sel + 3'd1);

    // Sequencer FSM; every output is a register so done and wrap have no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
            cfg_dwell <= '0;
            cfg_cont  <= 1'b0;
            cfg_down  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    wrap <= 1'b0;
                    // stop wins over start when both are high.
                    if (start && !stop) begin
                        state     <= SCAN;
                        sel       <= dir_down ? 3'd7 : 3'd0;
                        cnt       <= dwell;
                        cfg_dwell <= dwell;
                        cfg_cont  <= mode_cont;
                        cfg_down  <= dir_down;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        sel       <= 3'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state     <= IDLE;
                        sel       <= 3'd0;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        wrap      <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt != '0) begin
                        cnt  <= cnt - 1'b1;
                        wrap <= 1'b0;
                    end else if (!at_last) begin
                        sel  <= sel_step;
                        cnt  <= cfg_dwell;
                        wrap <= 1'b0;
                    end else if (cfg_cont) begin
                        sel  <= first_idx;
                        cnt  <= cfg_dwell;
                        wrap <= 1'b1;
                    end else begin
                        // sel stays on the last index through DONE.
                        state     <= DONE;
                        sel_valid <= 1'b0;
                        done      <= 1'b1;
                        wrap      <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    sel       <= 3'd0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    wrap      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    sel       <= 3'd0;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    wrap      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
